mult_seq_hilo: RTL and testbench

//   Multi-cycle signed 32x32 multiplier with architectural HI/LO registers.

---
 rtl/mult_seq_hilo.sv | 106 ++++++++++
 tb/tb_mult_seq_hilo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_hilo.sv
// Sequential signed WIDTH x WIDTH multiplier with architectural HI/LO registers.
// Radix-2 shift-add on operand magnitudes, sign fixed up at the final write.
// Accepts a new multiply in IDLE or DONE, so back-to-back multiplies are possible.
module mult_seq_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               neg;
  logic [CNT_W-1:0]   cnt;

  // Magnitudes of the operands; the most negative value maps to itself,
  // which is its correct unsigned magnitude.
  always_comb begin
    a_mag = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
    b_mag = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
  end

  // One shift-add step: conditional add into the upper half, carry shifts in at the top.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_nxt = {sum, acc[WIDTH-1:1]};
    prod    = neg ? (~acc_nxt + 1'b1) : acc_nxt;
  end

  // Control FSM, datapath registers and HI/LO, all with registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (mthi) hi <= wr_data;
          if (mtlo) lo <= wr_data;
          if (start) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_nxt;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            hi    <= prod[2*WIDTH-1:WIDTH];
            lo    <= prod[WIDTH-1:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall  = busy & rd_req;
  assign hi_out = hi;
  assign lo_out = lo;

endmodule

// File: tb/tb_mult_seq_hilo.sv
// Scoreboard bench for mult_seq_hilo: expected products (from a 64-bit signed
// multiply) and their due cycle are queued at start; a monitor checks each done.
module tb_mult_seq_hilo;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wr_data = '0;
  logic        rd_req = 1'b0;
  logic        busy, done, stall;
  logic [31:0] hi_out, lo_out;

  mult_seq_hilo #(.WIDTH(32), .CNT_W(5)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op_a(op_a), .op_b(op_b),
    .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data), .rd_req(rd_req),
    .busy(busy), .done(done), .stall(stall), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] prod;
    int          due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding product and its due cycle.
  always @(negedge CLK) begin
    if (!RST && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("product", {hi_out, lo_out}, e.prod);
        chk("latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  // Issue a start that the DUT will accept; call between edges with DUT in IDLE or DONE.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    e.prod = model(a, b);
    e.due  = cyc + 33;
    q.push_back(e);
    @(posedge CLK); #1;
    start = 1'b0;
    op_a  = $urandom;
    op_b  = $urandom;
  endtask

  // Advance to the negedge where done is high; a missing done is a failed check.
  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!done && n < 40);
    if (!done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  logic [31:0] corner [6];
  logic [31:0] a, b;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'hffff_ffff;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7fff_ffff; corner[5] = 32'h0001_0000;

    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi_out, lo_out}, 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);

    // Directed corner products, with a read request checked while busy.
    issue(32'hffff_ffff, 32'h0000_0001);
    rd_req = 1'b1;
    @(negedge CLK);
    chk("stall_busy", 64'(stall), 64'd1);
    chk("busy_run", 64'(busy), 64'd1);
    wait_done();
    chk("stall_done", 64'(stall), 64'd0);
    rd_req = 1'b0;
    @(negedge CLK);
    chk("done_pulse_once", 64'(done), 64'd0);

    issue(32'd3, 32'd3);                 wait_done(); @(negedge CLK);
    issue(32'h8000_0000, 32'h8000_0000); wait_done(); @(negedge CLK);
    issue(32'h7fff_ffff, 32'h8000_0000); wait_done(); @(negedge CLK);

    // Start during RUN is ignored; start in DONE cycle is accepted.
    issue(32'd2, 32'd2);
    repeat (9) @(posedge CLK);
    #1 start = 1'b1; op_a = 32'd5; op_b = 32'd5;
    @(posedge CLK); #1 start = 1'b0;
    wait_done();
    chk("ignored_start_lo", 64'(lo_out), 64'd4);
    issue(32'd5, 32'd5);
    // mthi during RUN is ignored: HI keeps the previous product until the new one lands.
    mthi = 1'b1; wr_data = 32'h1234;
    @(posedge CLK); #1 mthi = 1'b0;
    @(negedge CLK);
    chk("mthi_run_ignored", 64'(hi_out), 64'd0);
    wait_done();
    chk("b2b_lo", 64'(lo_out), 64'd25);
    @(negedge CLK);

    // mthi / mtlo in IDLE.
    mthi = 1'b1; wr_data = 32'h1234;
    @(posedge CLK); #1 mthi = 1'b0;
    chk("mthi_idle", {hi_out, lo_out}, {32'h1234, 32'd25});
    mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hdead_beef;
    @(posedge CLK); #1 mthi = 1'b0; mtlo = 1'b0;
    chk("mthi_mtlo_both", {hi_out, lo_out}, {32'hdead_beef, 32'hdead_beef});

    // mtlo together with an accepted start: written at accept, product overwrites later.
    mtlo = 1'b1; wr_data = 32'h5555_aaaa;
    issue(32'hffff_fffd, 32'd7);
    mtlo = 1'b0;
    chk("mtlo_with_start", 64'(lo_out), 64'h5555_aaaa);
    wait_done(); @(negedge CLK);

    // Reset mid-RUN aborts without a done pulse and clears HI/LO.
    issue(32'd123, 32'd456);
    repeat (9) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;
    q.delete();
    @(negedge CLK);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi_out, lo_out}, 64'd0);
    repeat (40) @(negedge CLK);
    issue(32'hffff_fff0, 32'hffff_fff0); wait_done(); @(negedge CLK);

    // Randomized products, mixing corner operands, with random back-to-back restarts.
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      issue(a, b);
      wait_done();
      if ($urandom_range(0, 1) == 0) @(negedge CLK);
    end

    repeat (3) @(negedge CLK);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
